// File: rtl/mem_trace_checker.sv
// Equivalence checker for a reference and a core-under-test memory trace.
// Lockstep (MODE=0) or skew-tolerant transaction compare (MODE=1).
module mem_trace_checker #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int MODE   = 0
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     ref_valid,
  input  logic                     uut_valid,
  input  logic                     ref_ready,
  input  logic                     uut_ready,
  input  logic                     ref_instr,
  input  logic                     uut_instr,
  input  logic [ADDR_W-1:0]        ref_addr,
  input  logic [ADDR_W-1:0]        uut_addr,
  input  logic [DATA_W-1:0]        ref_wdata,
  input  logic [DATA_W-1:0]        uut_wdata,
  input  logic [DATA_W/8-1:0]      ref_wstrb,
  input  logic [DATA_W/8-1:0]      uut_wstrb,
  input  logic                     ref_trap,
  input  logic                     uut_trap,
  output logic                     mismatch,
  output logic [4:0]               cause,
  output logic [15:0]              err_count,
  output logic [31:0]              match_count,
  output logic                     pending,
  output logic [$clog2(DEPTH):0]   skew
);

  localparam int SW = DATA_W / 8;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = 1 + ADDR_W + SW + DATA_W;
  localparam int RW = 1 + BW;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  function automatic logic [DATA_W-1:0] f_bytes(input logic [SW-1:0] s);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < SW; i++) m[8*i +: 8] = {8{s[i]}};
    return m;
  endfunction

  function automatic logic [4:0] f_cmp(input logic [RW-1:0] a,
                                       input logic [RW-1:0] b);
    logic [4:0] e;
    e    = '0;
    e[0] = a[RW-1] != b[RW-1];
    e[1] = a[RW-2 -: ADDR_W+1] != b[RW-2 -: ADDR_W+1];
    e[2] = a[DATA_W +: SW] != b[DATA_W +: SW];
    e[3] = a[DATA_W-1:0] != b[DATA_W-1:0];
    return e;
  endfunction

  logic              r_ref_tq, r_uut_tq;
  logic [CW-1:0]     r_ref_wp, r_ref_rp, r_uut_wp, r_uut_rp;
  logic [RW-1:0]     r_ref_mem [DEPTH];
  logic [RW-1:0]     r_uut_mem [DEPTH];

  logic              w_tx;
  logic [DATA_W-1:0] w_ref_md, w_uut_md;
  logic              w_ref_acc, w_uut_acc, w_ref_edge, w_uut_edge;
  logic [BW-1:0]     w_ref_body, w_uut_body;
  logic [RW-1:0]     w_ref_rec, w_uut_rec, w_ref_head, w_uut_head;
  logic [CW-1:0]     w_ref_cnt, w_uut_cnt;
  logic              w_ref_full, w_uut_full, w_ref_empty, w_uut_empty;
  logic              w_pop, w_ref_push, w_uut_push;
  logic              w_ref_wr, w_uut_wr, w_ref_ovf, w_uut_ovf;
  logic [CW-1:0]     w_ref_wp_n, w_ref_rp_n, w_uut_wp_n, w_uut_rp_n;
  logic [CW-1:0]     w_ref_cnt_n, w_uut_cnt_n, w_skew_n;
  logic [4:0]        w_tx_cmp, w_ls_err, w_err;
  logic              w_match;

  assign w_tx        = (MODE != 0);
  assign w_ref_md    = ref_wdata & f_bytes(ref_wstrb);
  assign w_uut_md    = uut_wdata & f_bytes(uut_wstrb);
  assign w_ref_acc   = ref_valid & ref_ready;
  assign w_uut_acc   = uut_valid & uut_ready;
  assign w_ref_edge  = ref_trap & ~r_ref_tq;
  assign w_uut_edge  = uut_trap & ~r_uut_tq;
  assign w_ref_body  = w_ref_acc ?
                       {ref_instr, ref_addr, ref_wstrb, w_ref_md} : '0;
  assign w_uut_body  = w_uut_acc ?
                       {uut_instr, uut_addr, uut_wstrb, w_uut_md} : '0;
  assign w_ref_rec   = {w_ref_edge, w_ref_body};
  assign w_uut_rec   = {w_uut_edge, w_uut_body};

  assign w_ref_cnt   = r_ref_wp - r_ref_rp;
  assign w_uut_cnt   = r_uut_wp - r_uut_rp;
  assign w_ref_full  = w_ref_cnt == FULL;
  assign w_uut_full  = w_uut_cnt == FULL;
  assign w_ref_empty = w_ref_cnt == '0;
  assign w_uut_empty = w_uut_cnt == '0;

  assign w_pop       = w_tx & ~w_ref_empty & ~w_uut_empty;
  assign w_ref_push  = w_tx & (w_ref_acc | w_ref_edge);
  assign w_uut_push  = w_tx & (w_uut_acc | w_uut_edge);
  assign w_ref_wr    = w_ref_push & (~w_ref_full | w_pop);
  assign w_uut_wr    = w_uut_push & (~w_uut_full | w_pop);
  assign w_ref_ovf   = w_ref_push & w_ref_full & ~w_pop;
  assign w_uut_ovf   = w_uut_push & w_uut_full & ~w_pop;

  assign w_ref_head  = r_ref_mem[r_ref_rp[PW-1:0]];
  assign w_uut_head  = r_uut_mem[r_uut_rp[PW-1:0]];
  assign w_tx_cmp    = f_cmp(w_ref_head, w_uut_head);

  assign w_ref_wp_n  = r_ref_wp + CW'(w_ref_wr);
  assign w_uut_wp_n  = r_uut_wp + CW'(w_uut_wr);
  assign w_ref_rp_n  = r_ref_rp + CW'(w_pop);
  assign w_uut_rp_n  = r_uut_rp + CW'(w_pop);
  assign w_ref_cnt_n = w_ref_wp_n - w_ref_rp_n;
  assign w_uut_cnt_n = w_uut_wp_n - w_uut_rp_n;
  assign w_skew_n    = (w_ref_cnt_n >= w_uut_cnt_n) ?
                       w_ref_cnt_n - w_uut_cnt_n :
                       w_uut_cnt_n - w_ref_cnt_n;

  // Per-cycle error bits and match strobe for the selected mode
  always_comb begin
    w_ls_err    = '0;
    w_ls_err[0] = (ref_valid != uut_valid) || (ref_trap != uut_trap);
    if (ref_valid) begin
      w_ls_err[1] = {ref_instr, ref_addr} != {uut_instr, uut_addr};
      w_ls_err[2] = ref_wstrb != uut_wstrb;
      w_ls_err[3] = w_ref_md != w_uut_md;
    end
    if (w_tx) begin
      w_err   = (w_pop ? w_tx_cmp : 5'b0) |
                {w_ref_ovf | w_uut_ovf, 4'b0};
      w_match = w_pop && (w_tx_cmp == 5'b0);
    end else begin
      w_err   = w_ls_err;
      w_match = ref_valid && (w_ls_err == 5'b0);
    end
  end

  // Skew FIFOs, pointers and trap edge history
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ref_tq <= 1'b0;
      r_uut_tq <= 1'b0;
      r_ref_wp <= '0;
      r_ref_rp <= '0;
      r_uut_wp <= '0;
      r_uut_rp <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_ref_mem[i] <= '0;
        r_uut_mem[i] <= '0;
      end
    end else begin
      r_ref_tq <= ref_trap;
      r_uut_tq <= uut_trap;
      r_ref_wp <= w_ref_wp_n;
      r_ref_rp <= w_ref_rp_n;
      r_uut_wp <= w_uut_wp_n;
      r_uut_rp <= w_uut_rp_n;
      if (w_ref_wr) r_ref_mem[r_ref_wp[PW-1:0]] <= w_ref_rec;
      if (w_uut_wr) r_uut_mem[r_uut_wp[PW-1:0]] <= w_uut_rec;
    end
  end

  // Sticky first-error capture, counters and occupancy status
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mismatch    <= 1'b0;
      cause       <= '0;
      err_count   <= '0;
      match_count <= '0;
      pending     <= 1'b0;
      skew        <= '0;
    end else begin
      if (|w_err) begin
        if (!mismatch) begin
          mismatch <= 1'b1;
          cause    <= w_err;
        end
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end
      if (w_match) match_count <= match_count + 32'd1;
      pending <= (|w_ref_cnt_n) | (|w_uut_cnt_n);
      skew    <= w_skew_n;
    end
  end

endmodule
